// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes driven on ctl and the driver FSM state type.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_OP_ZERO = 3'd0,
        ALU_OP_ONE  = 3'd1,
        ALU_OP_A    = 3'd2,
        ALU_OP_B    = 3'd3,
        ALU_OP_ADD  = 3'd4,
        ALU_OP_SUB  = 3'd5,
        ALU_OP_AND  = 3'd6,
        ALU_OP_OR   = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE,
        RESULT
    } drv_state_t;

endpackage

// File: rtl/alu_driver.sv
// ALU front end: holds one command until the frame tick, issues it for one cycle, holds the result.
// Optional flags_o output ({neg,zero} of C) is enabled by defining ALU_DRIVER_FLAGS_EN.
module alu_driver
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 tick_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [2:0]           cmd_op_i,
    input  logic                 cmd_chain_i,
    input  logic [WIDTH-1:0]     cmd_a_i,
    input  logic [WIDTH-1:0]     cmd_b_i,
    output logic                 en_o,
    output logic [2:0]           ctl_o,
    output logic [2*WIDTH-1:0]   AB_o,
    input  logic [2*WIDTH-1:0]   BC_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [WIDTH-1:0]     res_b_o,
`ifdef ALU_DRIVER_FLAGS_EN
    output logic [WIDTH-1:0]     res_c_o,
    output logic [1:0]           flags_o
`else
    output logic [WIDTH-1:0]     res_c_o
`endif
);

    drv_state_t           state_q, state_d;
    alu_op_t              op_q, op_d;
    logic [2*WIDTH-1:0]   ab_q, ab_d;
    logic [2*WIDTH-1:0]   hist_q, hist_d;
    logic [WIDTH-1:0]     res_b_q, res_b_d;
    logic [WIDTH-1:0]     res_c_q, res_c_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            op_q    <= ALU_OP_ZERO;
            ab_q    <= '0;
            hist_q  <= '0;
            res_b_q <= '0;
            res_c_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ab_q    <= ab_d;
            hist_q  <= hist_d;
            res_b_q <= res_b_d;
            res_c_q <= res_c_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ab_d        = ab_q;
        hist_d      = hist_q;
        res_b_d     = res_b_q;
        res_c_d     = res_c_q;
        cmd_ready_o = 1'b0;
        en_o        = 1'b0;
        ctl_o       = '0;
        AB_o        = '0;
        res_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    op_d    = alu_op_t'(cmd_op_i);
                    ab_d    = cmd_chain_i ? hist_q : {cmd_a_i, cmd_b_i};
                    state_d = WAIT;
                end
            end
            // A tick coincident with the accept is seen only from IDLE, so it never issues.
            WAIT: begin
                if (tick_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                en_o    = 1'b1;
                ctl_o   = op_q;
                AB_o    = ab_q;
                res_b_d = BC_i[2*WIDTH-1:WIDTH];
                res_c_d = BC_i[WIDTH-1:0];
                hist_d  = BC_i;
                state_d = RESULT;
            end
            RESULT: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_b_o = res_b_q;
    assign res_c_o = res_c_q;

`ifdef ALU_DRIVER_FLAGS_EN
    logic [1:0] flags_q, flags_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (state_q == ISSUE) begin
            flags_d = {BC_i[WIDTH-1], ~|BC_i[WIDTH-1:0]};
        end
    end

    assign flags_o = flags_q;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver wired to a behavioural ALU; tick every 20 cycles.
module tb_alu_driver;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n_i;
    logic           tick_i;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    logic [2:0]     cmd_op_i;
    logic           cmd_chain_i;
    logic [W-1:0]   cmd_a_i;
    logic [W-1:0]   cmd_b_i;
    logic           en_o;
    logic [2:0]     ctl_o;
    logic [2*W-1:0] AB_o;
    logic [2*W-1:0] BC_i;
    logic           res_valid_o;
    logic           res_ready_i;
    logic [W-1:0]   res_b_o;
    logic [W-1:0]   res_c_o;
`ifdef ALU_DRIVER_FLAGS_EN
    logic [1:0]     flags_o;
`endif

    always #5 clk = ~clk;

    alu_driver #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .tick_i      (tick_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_chain_i (cmd_chain_i),
        .cmd_a_i     (cmd_a_i),
        .cmd_b_i     (cmd_b_i),
        .en_o        (en_o),
        .ctl_o       (ctl_o),
        .AB_o        (AB_o),
        .BC_i        (BC_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_b_o     (res_b_o),
`ifdef ALU_DRIVER_FLAGS_EN
        .res_c_o     (res_c_o),
        .flags_o     (flags_o)
`else
        .res_c_o     (res_c_o)
`endif
    );

    function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            3'd0:    return '0;
            3'd1:    return W'(1);
            3'd2:    return a;
            3'd3:    return b;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Behavioural ALU: {B, f(A,B)} while enabled, zero otherwise.
    always_comb begin
        BC_i = '0;
        if (en_o) BC_i = {AB_o[W-1:0], alu_ref(ctl_o, AB_o[2*W-1:W], AB_o[W-1:0])};
    end

    typedef struct packed {
        logic [2:0]     ctl;
        logic [2*W-1:0] ab;
        logic [2*W-1:0] bc;
    } exp_t;

    exp_t           exp_q[$];
    logic [2*W-1:0] hist;
    logic [2*W-1:0] last_ab;
    int             checks = 0;
    int             errors = 0;
    int unsigned    cyc = 0;
    bit             rdy_rand = 1'b0;
    logic           rdy_force = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick_i      = (cyc % 20 == 0);
        res_ready_i = rdy_rand ? ($urandom_range(0, 2) == 0) : rdy_force;
    endtask

    task automatic send(input logic [2:0] op, input logic chain, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit align_tick);
        int unsigned n = 0;
        logic [2*W-1:0] ops;
        exp_t e;
        while (!(cmd_ready_o && (!align_tick || tick_i)) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            chk("send_timeout", 32'd1, 32'd0);
            return;
        end
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_chain_i = chain;
        cmd_a_i     = a;
        cmd_b_i     = b;
        ops    = chain ? hist : {a, b};
        e.ctl  = op;
        e.ab   = ops;
        e.bc   = {ops[W-1:0], alu_ref(op, ops[2*W-1:W], ops[W-1:0])};
        hist   = e.bc;
        exp_q.push_back(e);
        step();
        cmd_valid_i = 1'b0;
        cmd_a_i     = $urandom();
        cmd_b_i     = $urandom();
    endtask

    task automatic wait_res(input string name, input logic [W-1:0] eb, input logic [W-1:0] ec);
        int unsigned n = 0;
        while (!res_valid_o && n < 200) begin
            step();
            n++;
        end
        chk({name, "_valid"}, res_valid_o, 1'b1);
        chk({name, "_b"}, res_b_o, eb);
        chk({name, "_c"}, res_c_o, ec);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        step();
        step();
        rst_n_i = 1'b1;
        exp_q.delete();
        hist = '0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, cmd_ready_o, 1'b1);
        chk({name, "_en"}, en_o, 1'b0);
        chk({name, "_ctl_ab"}, {ctl_o, AB_o}, '0);
        chk({name, "_valid"}, res_valid_o, 1'b0);
        chk({name, "_res"}, {res_b_o, res_c_o}, '0);
`ifdef ALU_DRIVER_FLAGS_EN
        chk({name, "_flags"}, flags_o, 2'b00);
`endif
    endtask

    // Monitor: protocol/timing checks every cycle, result comparison on handoff.
    bit             busy = 1'b0, issued = 1'b0;
    bit             p_exp_en = 1'b0, p_en = 1'b0, p_valid = 1'b0, p_rdy = 1'b0;
    logic [2*W-1:0] p_res = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n_i) begin
            busy = 1'b0; issued = 1'b0;
            p_exp_en = 1'b0; p_en = 1'b0; p_valid = 1'b0; p_rdy = 1'b0;
        end else begin
            chk("cmd_ready", cmd_ready_o, !busy);
            chk("en_timing", en_o, p_exp_en);
            if (en_o) begin
                if (exp_q.size() == 0) begin
                    chk("issue_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("issue_ctl", ctl_o, exp_q[0].ctl);
                    chk("issue_ab", AB_o, exp_q[0].ab);
                end
                last_ab = AB_o;
                issued  = 1'b1;
            end else begin
                chk("quiet_ctl_ab", {ctl_o, AB_o}, '0);
            end
            chk("res_valid", res_valid_o, p_en || (p_valid && !p_rdy));
            if (p_valid && !p_rdy && res_valid_o)
                chk("res_stable", {res_b_o, res_c_o}, p_res);
            if (res_valid_o && res_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_bc", {res_b_o, res_c_o}, e.bc);
`ifdef ALU_DRIVER_FLAGS_EN
                    chk("result_flags", flags_o, {e.bc[W-1], e.bc[W-1:0] == '0});
`endif
                end
            end
            p_exp_en = busy && !issued && tick_i;
            if (cmd_valid_i && cmd_ready_o) begin
                busy = 1'b1; issued = 1'b0;
            end
            if (res_valid_o && res_ready_i) begin
                busy = 1'b0; issued = 1'b0;
            end
            p_en    = en_o;
            p_valid = res_valid_o;
            p_rdy   = res_ready_i;
            p_res   = {res_b_o, res_c_o};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst_n_i     = 1'b0;
        tick_i      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = '0;
        cmd_chain_i = 1'b0;
        cmd_a_i     = '0;
        cmd_b_i     = '0;
        res_ready_i = 1'b1;
        hist        = '0;
        last_ab     = '0;
        do_reset();
        chk_reset_outputs("reset");

        send(3'd5, 1'b0, 8'h05, 8'h07, 1'b0);
        wait_res("sub_wrap", 8'h07, 8'hFE);
`ifdef ALU_DRIVER_FLAGS_EN
        chk("sub_flags", flags_o, 2'b10);
`endif

        send(3'd4, 1'b0, 8'h30, 8'h12, 1'b0);
        wait_res("add", 8'h12, 8'h42);

        send(3'd7, 1'b1, 8'hFF, 8'hFF, 1'b0);
        wait_res("or_chain", 8'h42, 8'h52);
        chk("or_chain_ab", last_ab, 16'h1242);

        rdy_force = 1'b0;
        send(3'd4, 1'b0, 8'h01, 8'h02, 1'b0);
        wait_res("hold", 8'h02, 8'h03);
        repeat (60) step();
        chk("hold_valid", res_valid_o, 1'b1);
        chk("hold_ready", cmd_ready_o, 1'b0);
        chk("hold_res", {res_b_o, res_c_o}, 16'h0203);
        rdy_force = 1'b1;
        step();
        step();
        chk("release_valid", res_valid_o, 1'b0);
        chk("release_ready", cmd_ready_o, 1'b1);

        send(3'd6, 1'b0, 8'hF0, 8'h3C, 1'b1);
        wait_res("same_tick", 8'h3C, 8'h30);
        step();
        n = 0;
        while (!(tick_i && cmd_ready_o) && n < 100) begin step(); n++; end
        step();
        chk("idle_tick_en", en_o, 1'b0);

        n = 0;
        while (!tick_i && n < 100) begin step(); n++; end
        step();
        send(3'd4, 1'b0, 8'h09, 8'h09, 1'b0);
        repeat (3) step();
        do_reset();
        chk_reset_outputs("wait_reset");
        send(3'd4, 1'b1, 8'hAA, 8'h55, 1'b0);
        wait_res("chain_after_reset", 8'h00, 8'h00);
        chk("chain_after_reset_ab", last_ab, 16'h0000);

        rdy_rand = 1'b1;
        for (int unsigned i = 0; i < 40; i++) begin
            send(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), W'($urandom()),
                 W'($urandom()), ($urandom_range(0, 4) == 0));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin step(); n++; end
        chk("drain", exp_q.size(), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
